// File: rtl/ysyx_23060096_mc_ctrl.sv
// ysyx_23060096_mc_ctrl: multi-cycle RV32 control FSM; optional retired-instruction counter under `YSYX_23060096_INSTRET_EN
module ysyx_23060096_mc_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic [31:0] ir,
  output logic [2:0]  ext_op,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        halted,
  output logic        halt_code,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t      r_state;
  logic [31:0] r_ir;
  logic        r_halted;
  logic        r_halt_code;
  logic [6:0]  w_opc;
  logic        w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_op;
  logic        w_ebreak, w_legal;
  logic        w_act, w_exec, w_mem, w_wb;
  assign w_opc    = r_ir[6:0];
  assign w_lui    = w_opc == 7'b0110111;
  assign w_auipc  = w_opc == 7'b0010111;
  assign w_jal    = w_opc == 7'b1101111;
  assign w_jalr   = w_opc == 7'b1100111;
  assign w_br     = w_opc == 7'b1100011;
  assign w_ld     = w_opc == 7'b0000011;
  assign w_st     = w_opc == 7'b0100011;
  assign w_opi    = w_opc == 7'b0010011;
  assign w_op     = w_opc == 7'b0110011;
  assign w_ebreak = r_ir == 32'h0010_0073;
  assign w_legal  = w_lui || w_auipc || w_jal || w_jalr || w_br || w_ld || w_st || w_opi || w_op;
  // sequence the instruction steps, latch the fetched word and record why we halted
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_ir        <= '0;
      r_halted    <= 1'b0;
      r_halt_code <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (inst_valid) begin
          r_ir    <= inst;
          r_state <= S_DECODE;
        end
        S_DECODE: if (w_ebreak || !w_legal) begin
          r_state     <= S_HALT;
          r_halted    <= 1'b1;
          r_halt_code <= !w_ebreak;
        end else r_state <= S_EXEC;
        S_EXEC:   r_state <= w_br ? S_FETCH : (w_ld || w_st) ? S_MEM : S_WB;
        S_MEM:    if (mem_ack) r_state <= w_st ? S_FETCH : S_WB;
        S_WB:     r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  // branch resolution needs br_taken in the same cycle, so strobes decode combinationally from state and ir
  assign w_act      = r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB};
  assign w_exec     = r_state == S_EXEC;
  assign w_mem      = r_state == S_MEM;
  assign w_wb       = r_state == S_WB;
  assign inst_ready = r_state == S_FETCH;
  assign ir         = r_ir;
  assign ext_op     = (w_lui || w_auipc) ? 3'b001 : w_jal ? 3'b100 : w_st ? 3'b010 : w_br ? 3'b011 : 3'b000;
  assign alu_a_sel  = w_act && (w_auipc || w_jal || w_br);
  assign alu_b_sel  = w_act && !(w_op || w_br);
  assign mem_req    = w_mem;
  assign mem_we     = w_mem && w_st;
  assign reg_we     = w_wb && (r_ir[11:7] != 5'd0);
  assign pc_we      = (w_exec && w_br) || (w_mem && mem_ack && w_st) || w_wb;
  assign pc_sel     = ((w_exec && w_br && br_taken) || (w_wb && w_jal)) ? 2'b01 : (w_wb && w_jalr) ? 2'b10 : 2'b00;
  assign wb_sel     = !w_wb ? 2'b00 : w_ld ? 2'b01 : (w_jal || w_jalr) ? 2'b10 : 2'b00;
  assign halted     = r_halted;
  assign halt_code  = r_halt_code;
`ifdef YSYX_23060096_INSTRET_EN
  logic [31:0] r_instret;
  // one count per pc_we pulse, wrapping naturally at 32 bits
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_instret <= '0;
    else if (pc_we) r_instret <= r_instret + 32'd1;
  assign instret = r_instret;
`else
  assign instret = '0;
`endif
endmodule

// File: tb/tb_ysyx_23060096_mc_ctrl.sv
// tb_ysyx_23060096_mc_ctrl: scoreboard bench for the multi-cycle control FSM
module tb_ysyx_23060096_mc_ctrl;
  logic        clk = 1'b0;
  logic        rstn, inst_valid, br_taken, mem_ack;
  logic [31:0] inst;
  logic        inst_ready, alu_a_sel, alu_b_sel, mem_req, mem_we, reg_we, pc_we, halted, halt_code;
  logic [31:0] ir, instret;
  logic [2:0]  ext_op;
  logic [1:0]  wb_sel, pc_sel;
`ifdef YSYX_23060096_INSTRET_EN
  localparam int IE = 1;
`else
  localparam int IE = 0;
`endif
  localparam logic [31:0] ADDI = 32'h0050_0093, BEQ = 32'h0000_0463, LUI = 32'h1234_52B7, ADD = 32'h0020_81B3;
  localparam logic [31:0] JALR = 32'h0001_00E7, JAL = 32'h0080_006F, SW = 32'h0020_A023, LW = 32'h0000_A103;
  localparam logic [31:0] EBRK = 32'h0010_0073, ILL = 32'h0000_007F;
  typedef struct packed {
    logic [7:0] id;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [2:0] ext_op;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int n_cmp = 0, n_bad = 0;
  ysyx_23060096_mc_ctrl dut (
    .clk(clk), .rstn(rstn), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .br_taken(br_taken), .mem_ack(mem_ack), .ir(ir), .ext_op(ext_op), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel),
    .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted), .halt_code(halt_code), .instret(instret)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic expect_ret(input logic [7:0] id, input logic [1:0] ps, input logic rw, input logic [1:0] ws, input logic [2:0] eo);
    exp_t e;
    e.id = id;
    e.pc_sel = ps;
    e.reg_we = rw;
    e.wb_sel = ws;
    e.ext_op = eo;
    q.push_back(e);
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] i);
    int k = 0;
    while (!inst_ready && k < 50) begin
      cyc;
      k++;
    end
    if (!inst_ready) chk("send_timeout_ready", {31'd0, inst_ready}, 32'd1);
    inst = i;
    inst_valid = 1'b1;
    cyc;
    inst_valid = 1'b0;
  endtask
  task automatic check_reset(input string nm);
    chk({nm, "_strobes"}, {23'd0, inst_ready, mem_req, mem_we, reg_we, pc_we, alu_a_sel, alu_b_sel, halted, halt_code}, 32'd0);
    chk({nm, "_selects"}, {25'd0, pc_sel, wb_sel, ext_op}, 32'd0);
    chk({nm, "_ir"}, ir, 32'd0);
    chk({nm, "_instret"}, instret, 32'd0);
  endtask
  task automatic do_reset(input string nm);
    cyc;
    rstn = 1'b0;
    #1;
    check_reset(nm);
    cyc;
    cyc;
    rstn = 1'b1;
    chk({nm, "_idle_ready"}, {31'd0, inst_ready}, 32'd0);
    cyc;
    chk({nm, "_fetch_ready"}, {31'd0, inst_ready}, 32'd1);
  endtask
  // monitor: every pc_we pulse retires the oldest expected instruction
  always @(negedge clk)
    if (rstn === 1'b1) begin
      if (reg_we === 1'b1 && pc_we !== 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_reg_we: got 1 expected 0 (ir %h)", ir);
      end
      if (pc_we === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pc_we: got 1 expected 0 (ir %h)", ir);
        end else begin
          m_e = q.pop_front();
          chk($sformatf("ret%0d_pc_sel", m_e.id), {30'd0, pc_sel}, {30'd0, m_e.pc_sel});
          chk($sformatf("ret%0d_reg_we", m_e.id), {31'd0, reg_we}, {31'd0, m_e.reg_we});
          chk($sformatf("ret%0d_wb_sel", m_e.id), {30'd0, wb_sel}, {30'd0, m_e.wb_sel});
          chk($sformatf("ret%0d_ext_op", m_e.id), {29'd0, ext_op}, {29'd0, m_e.ext_op});
        end
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int cnt;
    rstn = 1'b1;
    inst_valid = 1'b1;
    inst = ADDI;
    br_taken = 1'b0;
    mem_ack = 1'b0;
    #1 rstn = 1'b0;
    #3;
    check_reset("por");
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    chk("c1_idle_ready", {31'd0, inst_ready}, 32'd0);
    expect_ret(1, 2'b00, 1'b1, 2'b00, 3'b000);
    cyc;
    chk("c2_fetch_ready", {31'd0, inst_ready}, 32'd1);
    cyc;
    inst_valid = 1'b0;
    chk("addi_ir", ir, ADDI);
    chk("addi_dec_ext_op", {29'd0, ext_op}, 32'd0);
    chk("addi_dec_alu_b", {31'd0, alu_b_sel}, 32'd1);
    cyc;
    chk("addi_exec_alu", {30'd0, alu_a_sel, alu_b_sel}, 32'd1);
    chk("addi_exec_pc_we", {31'd0, pc_we}, 32'd0);
    cyc;
    chk("addi_c5_wb", {28'd0, reg_we, pc_we, wb_sel}, 32'b1100);
    expect_ret(2, 2'b01, 1'b0, 2'b00, 3'b011);
    send(BEQ);
    chk("beq_dec_ext_op", {29'd0, ext_op}, 32'd3);
    cyc;
    br_taken = 1'b1;
    #1;
    chk("beq_exec_pc", {29'd0, pc_we, pc_sel}, 32'b101);
    chk("beq_exec_alu", {30'd0, alu_a_sel, alu_b_sel}, 32'b10);
    cyc;
    br_taken = 1'b0;
    chk("beq_next_fetch", {31'd0, inst_ready}, 32'd1);
    expect_ret(3, 2'b00, 1'b0, 2'b00, 3'b011);
    send(BEQ);
    cyc;
    expect_ret(4, 2'b00, 1'b1, 2'b00, 3'b001);
    send(LUI);
    cyc;
    chk("lui_exec_alu", {30'd0, alu_a_sel, alu_b_sel}, 32'b01);
    cyc;
    expect_ret(5, 2'b00, 1'b1, 2'b00, 3'b000);
    send(ADD);
    cyc;
    chk("add_exec_alu", {30'd0, alu_a_sel, alu_b_sel}, 32'b00);
    cyc;
    expect_ret(6, 2'b10, 1'b1, 2'b10, 3'b000);
    send(JALR);
    cyc;
    cyc;
    expect_ret(7, 2'b01, 1'b0, 2'b10, 3'b100);
    send(JAL);
    chk("jal_dec_ext_op", {29'd0, ext_op}, 32'd4);
    cyc;
    chk("jal_exec_alu", {30'd0, alu_a_sel, alu_b_sel}, 32'b11);
    cyc;
    chk("jal_wb_reg_we", {31'd0, reg_we}, 32'd0);
    expect_ret(8, 2'b00, 1'b0, 2'b00, 3'b010);
    send(SW);
    cyc;
    cyc;
    mem_ack = 1'b1;
    #1;
    chk("sw_mem_req_we", {30'd0, mem_req, mem_we}, 32'b11);
    cyc;
    mem_ack = 1'b0;
    chk("sw_after_fetch", {30'd0, mem_req, inst_ready}, 32'b01);
    expect_ret(9, 2'b00, 1'b1, 2'b01, 3'b000);
    send(LW);
    cyc;
    cyc;
    chk("lw_mem_we", {31'd0, mem_we}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ack = (k == 3);
      #1;
      cnt += int'(mem_req);
      if (k < 3) cyc;
    end
    cyc;
    mem_ack = 1'b0;
    chk("lw_mem_req_cycles", cnt, 32'd4);
    chk("lw_wb", {27'd0, mem_req, reg_we, pc_we, wb_sel}, 32'b01101);
    cyc;
    chk("lw_instret", instret, IE ? 32'd9 : 32'd0);
    send(EBRK);
    cyc;
    chk("ebreak_halt", {29'd0, halted, halt_code, inst_ready}, 32'b100);
    inst = ADDI;
    inst_valid = 1'b1;
    repeat (3) cyc;
    inst_valid = 1'b0;
    chk("ebreak_sticky", {29'd0, halted, halt_code, inst_ready}, 32'b100);
    chk("ebreak_ir_kept", ir, EBRK);
    chk("ebreak_instret", instret, IE ? 32'd9 : 32'd0);
    do_reset("rst1");
    send(ILL);
    cyc;
    chk("illegal_halt", {29'd0, halted, halt_code, pc_we}, 32'b110);
    do_reset("rst2");
    send(LW);
    cyc;
    cyc;
    chk("midmem_req", {31'd0, mem_req}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    check_reset("midmem");
    cyc;
    cyc;
    rstn = 1'b1;
    chk("midmem_idle_ready", {31'd0, inst_ready}, 32'd0);
    cyc;
    chk("midmem_fetch_ready", {31'd0, inst_ready}, 32'd1);
    chk("midmem_instret", instret, 32'd0);
    expect_ret(10, 2'b00, 1'b1, 2'b00, 3'b000);
    send(ADDI);
    cyc;
    cyc;
    cyc;
    chk("final_instret", instret, IE ? 32'd1 : 32'd0);
    repeat (3) cyc;
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_23060096_mc_ctrl.md
# ysyx_23060096_mc_ctrl

Multi-cycle control FSM for the single-issue RV32 core. Handshakes instructions from the fetch unit, latches them into an instruction register and drives the immediate-generator select (`ext_op`). Sequences execute, memory and write-back steps and drives the datapath mux/enable controls. Halts on `ebreak` or an illegal opcode.

## Interface
- No parameters.
- `clk` in 1: core clock, rising-edge.
- `rstn` in 1: asynchronous, active-low reset.
- `inst` in 32: instruction from the fetch unit.
- `inst_valid` in 1: `inst` is valid.
- `inst_ready` out 1: controller accepts `inst`.
- `br_taken` in 1: branch comparator result, valid in EXEC.
- `mem_ack` in 1: data-memory access complete.
- `ir` out 32: latched instruction; `ir[31:7]` feeds the immediate generator.
- `ext_op` out 3: immediate type. 000 I, 001 U, 010 S, 011 B, 100 J.
- `alu_a_sel` out 1: ALU operand A. 0 rs1, 1 PC.
- `alu_b_sel` out 1: ALU operand B. 0 rs2, 1 imm.
- `mem_req` out 1: data-memory request.
- `mem_we` out 1: request is a store.
- `reg_we` out 1: register-file write enable.
- `wb_sel` out 2: write-back source. 00 ALU, 01 load data, 10 PC+4.
- `pc_we` out 1: PC update strobe.
- `pc_sel` out 2: next PC. 00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1.
- `halted` out 1: sticky halt.
- `halt_code` out 1: 0 ebreak, 1 illegal.
- `instret` out 32: retired-instruction count (see Configuration).

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoded in a state register; all outputs are decoded from state and `ir`.
- Opcode classes from `ir[6:0]`:
  - LUI 0110111, AUIPC 0010111 → U
  - JAL 1101111 → J
  - JALR 1100111 → I
  - BRANCH 1100011 → B
  - LOAD 0000011 → I
  - STORE 0100011 → S
  - OPIMM 0010011 → I
  - OP 0110011 → 000
  - SYSTEM: only `ir`==0x00100073 (ebreak) is legal.
  - Any other opcode is illegal.
- IDLE: lasts one cycle after reset release, then FETCH.
- FETCH: `inst_ready`=1. On `inst_valid`&&`inst_ready`, load `ir`<=`inst` and go to DECODE.
- DECODE: `ext_op` valid from here until the next FETCH.
  - ebreak → HALT with `halt_code`=0.
  - Illegal opcode → HALT with `halt_code`=1.
  - Otherwise → EXEC.
- EXEC: ALU selects per class.
  - AUIPC/JAL/BRANCH: a=PC.
  - OP/BRANCH: b=rs2.
  - All others: a=rs1, b=imm.
  - BRANCH: `pc_we`=1, `pc_sel`=`br_taken`?01:00, then FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM: `mem_req`=1 held until `mem_ack`; `mem_we`=1 for STORE.
  - On `mem_ack`, STORE: `pc_we`=1, `pc_sel`=00, then FETCH.
  - On `mem_ack`, LOAD: go to WB.
- WB (one cycle):
  - `reg_we`=(`ir[11:7]`!=0). `pc_we`=1.
  - `wb_sel`: 01 for LOAD, 10 for JAL/JALR, else 00.
  - `pc_sel`: 01 for JAL, 10 for JALR, else 00.
  - Then FETCH.
- HALT: absorbing until reset. `halted`=1; all strobes 0; `inst_ready`=0.
- Inputs are ignored outside their state: `inst_valid` outside FETCH, `mem_ack` outside MEM, `br_taken` outside EXEC.
- Exactly one `pc_we` pulse per retired instruction. No `pc_we` for halting instructions.

## Timing
- Reset (asynchronous, any state, including mid-MEM):
  - state → IDLE, `ir`=0.
  - `halted`=0, `halt_code`=0, `instret`=0.
  - All strobes and selects 0; `ext_op`=000.
- Minimum cycles per instruction, counting from the cycle in FETCH where the handshake completes until the next FETCH state:
  - Branch: 3 cycles (FETCH, DECODE, EXEC).
  - ALU/U/J: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Store: 4 + extra MEM wait cycles.
  - Load: 5 + extra MEM wait cycles.
- `mem_ack` in the first MEM cycle means zero wait.
- The `ir` update is visible the cycle after the handshake.
- `pc_we` is a single-cycle pulse; the PC register updates at that cycle's edge.
- `mem_req` may remain high indefinitely; there is no timeout.

## Configuration
- `YSYX_23060096_INSTRET_EN` defined: `instret` increments by 1 on every `pc_we` pulse and wraps from 0xFFFFFFFF to 0.
- Undefined: `instret` is tied to 0 and no counter flops are built.

## Test plan
- Reset release with `inst_valid`=1 and `inst`=0x00500093 (addi x1,x0,5):
  - `inst_ready` is high in cycle 2.
  - `ext_op`=000 and `alu_b_sel`=1 in DECODE/EXEC.
  - `reg_we`=1, `wb_sel`=00 and `pc_we`=1 in cycle 5.
- Taken beq 0x00000463 with `br_taken`=1: `pc_we`=1 and `pc_sel`=01 in EXEC; `reg_we` is never asserted; next state is FETCH.
- Load 0x0000A103 with `mem_ack` delayed 3 cycles:
  - `mem_req` is held for 4 cycles.
  - The following WB cycle has `reg_we`=1, `wb_sel`=01.
  - With the macro defined, `instret` increments by 1.
- jal x0 0x0080006F: in WB, `reg_we`=0 (rd=0), `pc_sel`=01, `ext_op`=100.
- Halt cases:
  - ebreak 0x00100073 → `halted`=1, `halt_code`=0; subsequent `inst_valid` is ignored.
  - opcode 0x7F → `halt_code`=1.
- Assert `rstn`=0 mid-MEM with `mem_req`=1:
  - `mem_req` drops immediately, asynchronously.
  - After release the controller passes through IDLE, then FETCH.
  - `instret`=0.
